// File: rtl/mem_io_ctrl.sv
// Memory-mapped display/switch peripheral: hex digit register with blanking,
// debounced switch vector, and a sticky change flag driving a level interrupt.
module mem_io_ctrl #(
    parameter int                DATA_W       = 16,
    parameter int                ADDR_W       = 16,
    parameter int                NUM_DIGITS   = 4,
    parameter int                NUM_SW       = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = 16'hFF00,
    parameter int                DEBOUNCE_CYC = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_W-1:0]       data_in,
    input  logic                    wren,
    input  logic                    rden,
    output logic [DATA_W-1:0]       q,
    output logic                    q_valid,
    input  logic [NUM_SW-1:0]       switches,
    output logic [7*NUM_DIGITS-1:0] seg,
    output logic                    sw_irq
);

    localparam int DISP_W = 4 * NUM_DIGITS;
    localparam int SEG_W  = 7 * NUM_DIGITS;
    localparam int CNT_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_ACCEPT
    } dbc_state_e;

    logic              hit;
    logic              wr;
    logic              rd;
    logic [1:0]        off;
    logic [DATA_W-1:0] rdata;

    logic [DISP_W-1:0] disp_q, disp_d;
    logic              en_q, en_d;
    logic              lzb_q, lzb_d;
    logic              chg_q, chg_d;
    logic [DATA_W-1:0] q_q, q_d;
    logic              qv_q, qv_d;
    logic [SEG_W-1:0]  seg_q, seg_d;

    logic [NUM_SW-1:0] sync1_q, sync2_q, prev_q;
    logic [NUM_SW-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, run_cnt;
    dbc_state_e        state_q, state_d;
    logic              accept;

    logic [3:0]        digit;
    logic              lead;

    assign hit = (address[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]);
    assign off = address[1:0];
    assign wr  = wren & hit;
    assign rd  = rden & hit;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0:    hex7 = 7'b1000000;
            4'h1:    hex7 = 7'b1111001;
            4'h2:    hex7 = 7'b0100100;
            4'h3:    hex7 = 7'b0110000;
            4'h4:    hex7 = 7'b0011001;
            4'h5:    hex7 = 7'b0010010;
            4'h6:    hex7 = 7'b0000010;
            4'h7:    hex7 = 7'b1111000;
            4'h8:    hex7 = 7'b0000000;
            4'h9:    hex7 = 7'b0010000;
            4'hA:    hex7 = 7'b0001000;
            4'hB:    hex7 = 7'b0000011;
            4'hC:    hex7 = 7'b1000110;
            4'hD:    hex7 = 7'b0100001;
            4'hE:    hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        rdata = '0;
        case (off)
            2'd0: rdata[DISP_W-1:0] = disp_q;
            2'd1: begin
                rdata[0] = en_q;
                rdata[1] = lzb_q;
            end
            2'd2:    rdata[NUM_SW-1:0] = stable_q;
            default: rdata[0] = chg_q;
        endcase
    end

    // The hold count only carries over while sync is unchanged inside COUNT;
    // any other cycle starts a fresh run at zero.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = 1'b0;
        run_cnt  = '0;
        if (state_q == ST_COUNT && sync2_q == prev_q) begin
            run_cnt = cnt_q;
        end
        if (sync2_q == stable_q) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (run_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
            state_d  = ST_ACCEPT;
            cnt_d    = '0;
            stable_d = sync2_q;
            accept   = 1'b1;
        end else begin
            state_d = ST_COUNT;
            cnt_d   = run_cnt + 1'b1;
        end
    end

    always_comb begin
        disp_d = disp_q;
        en_d   = en_q;
        lzb_d  = lzb_q;
        chg_d  = chg_q;
        if (wr) begin
            case (off)
                2'd0: disp_d = data_in[DISP_W-1:0];
                2'd1: begin
                    en_d  = data_in[0];
                    lzb_d = data_in[1];
                end
                2'd3: if (data_in[0]) chg_d = 1'b0;
                default: ;
            endcase
        end
        if (accept) begin
            chg_d = 1'b1;
        end
        q_d  = rd ? rdata : q_q;
        qv_d = rd;
    end

    // Blanking walks from the top digit and stops at the first nonzero one.
    always_comb begin
        seg_d = '1;
        lead  = lzb_q;
        digit = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            digit = disp_q[4*k +: 4];
            if (lead && k != 0 && digit == 4'd0) begin
                seg_d[7*k +: 7] = 7'b1111111;
            end else begin
                lead            = 1'b0;
                seg_d[7*k +: 7] = hex7(digit);
            end
        end
        if (!en_q) begin
            seg_d = '1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_q   <= '0;
            en_q     <= 1'b1;
            lzb_q    <= 1'b0;
            chg_q    <= 1'b0;
            q_q      <= '0;
            qv_q     <= 1'b0;
            seg_q    <= {NUM_DIGITS{7'b1000000}};
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            state_q  <= ST_IDLE;
        end else begin
            disp_q   <= disp_d;
            en_q     <= en_d;
            lzb_q    <= lzb_d;
            chg_q    <= chg_d;
            q_q      <= q_d;
            qv_q     <= qv_d;
            seg_q    <= seg_d;
            sync1_q  <= switches;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
        end
    end

    assign q       = q_q;
    assign q_valid = qv_q;
    assign seg     = seg_q;
    assign sw_irq  = chg_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Bench for mem_io_ctrl: directed scenarios plus random bus/switch traffic,
// checked by a monitor against a register-level reference model.
module tb_mem_io_ctrl;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] address = '0;
  logic [15:0] data_in = '0;
  logic        wren = 1'b0;
  logic        rden = 1'b0;
  logic [15:0] q;
  logic        q_valid;
  logic [7:0]  switches = '0;
  logic [27:0] seg;
  logic        sw_irq;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];

  // reference model state
  logic [15:0] m_disp;
  logic        m_en, m_lzb, m_chg, m_acc, m_same;
  logic [7:0]  m_stable;
  logic [27:0] m_seg;
  logic [7:0]  raw_hist[$];
  logic [6:0]  hex_pat[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  mem_io_ctrl #(
    .DATA_W(16), .ADDR_W(16), .NUM_DIGITS(4), .NUM_SW(8),
    .BASE_ADDR(16'hFF00), .DEBOUNCE_CYC(D)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .data_in(data_in),
    .wren(wren), .rden(rden), .q(q), .q_valid(q_valid),
    .switches(switches), .seg(seg), .sw_irq(sw_irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic in_win(input logic [15:0] a);
    return a[15:2] == 14'h3FC0;
  endfunction

  function automatic logic [27:0] exp_seg(input logic [15:0] disp, input logic en, input logic lzb);
    int top;
    int dig;
    logic [27:0] s;
    if (!en) return '1;
    top = 0;
    for (int k = 0; k < 4; k++) if (((disp >> (4 * k)) & 16'hF) != 0) top = k;
    s = '1;
    for (int k = 0; k < 4; k++) begin
      dig = int'((disp >> (4 * k)) & 16'hF);
      if (!lzb || k <= top) s[7*k +: 7] = hex_pat[dig];
    end
    return s;
  endfunction

  function automatic logic [15:0] model_read(input logic [1:0] off);
    case (off)
      2'd0: return m_disp;
      2'd1: return {14'd0, m_lzb, m_en};
      2'd2: return {8'd0, m_stable};
      default: return {15'd0, m_chg};
    endcase
  endfunction

  task automatic model_clear();
    m_disp = '0;
    m_en = 1'b1;
    m_lzb = 1'b0;
    m_chg = 1'b0;
    m_stable = '0;
    m_seg = {4{7'h40}};
    raw_hist.delete();
    repeat (D + 1) raw_hist.push_back(8'h00);
  endtask

  // A switch value is accepted once the synchronised input has shown the
  // same value, different from the accepted one, for D whole cycles.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_clear();
    end else begin
      m_seg = exp_seg(m_disp, m_en, m_lzb);
      m_same = 1'b1;
      for (int i = 1; i < D; i++) if (raw_hist[i] != raw_hist[0]) m_same = 1'b0;
      m_acc = m_same && (raw_hist[0] != m_stable);
      if (wren && in_win(address)) begin
        case (address[1:0])
          2'd0: m_disp = data_in;
          2'd1: begin m_en = data_in[0]; m_lzb = data_in[1]; end
          2'd3: if (data_in[0]) m_chg = 1'b0;
          default: ;
        endcase
      end
      if (m_acc) begin
        m_stable = raw_hist[0];
        m_chg = 1'b1;
      end
      void'(raw_hist.pop_front());
      raw_hist.push_back(switches);
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      chk("seg", seg, m_seg);
      chk("sw_irq", sw_irq, m_chg);
      if (q_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL read_q: q_valid=1 q=%h but no read outstanding", q);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (q !== e) begin
            bad++;
            $display("FAIL read_q: got %h expected %h", q, e);
          end
        end
      end
    end
  end

  // driver
  task automatic bus(input logic w, input logic r, input logic [15:0] a, input logic [15:0] d);
    wren = w;
    rden = r;
    address = a;
    data_in = d;
    if (r && in_win(a)) exp_q.push_back(model_read(a[1:0]));
    @(negedge clk);
    wren = 1'b0;
    rden = 1'b0;
  endtask

  initial begin
    int lat;
    logic [15:0] a;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_seg", seg, {4{7'h40}});
    chk("reset_q_valid", q_valid, 1'b0);
    chk("reset_q", q, 16'h0000);
    chk("reset_irq", sw_irq, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    bus(1'b0, 1'b1, 16'hFF01, 16'h0);
    chk("ctrl_read", q, 16'h0001);
    @(negedge clk);
    chk("q_valid_pulse", q_valid, 1'b0);

    bus(1'b1, 1'b0, 16'hFF00, 16'h1A70);
    @(negedge clk);
    chk("seg_1A70", seg, {7'h79, 7'h08, 7'h78, 7'h40});
    bus(1'b0, 1'b1, 16'hFF00, 16'h0);
    chk("disp_read", q, 16'h1A70);

    bus(1'b1, 1'b0, 16'hFF00, 16'h0070);
    bus(1'b1, 1'b0, 16'hFF01, 16'h0003);
    @(negedge clk);
    chk("seg_lzb", seg, {7'h7F, 7'h7F, 7'h78, 7'h40});
    bus(1'b1, 1'b0, 16'hFF01, 16'h0000);
    @(negedge clk);
    chk("seg_off", seg, 28'hFFFFFFF);
    bus(1'b1, 1'b0, 16'hFF01, 16'h0001);

    switches = 8'h05;
    repeat (2) @(negedge clk);
    switches = 8'h00;
    repeat (10) @(negedge clk);
    chk("glitch_irq", sw_irq, 1'b0);
    bus(1'b0, 1'b1, 16'hFF02, 16'h0);
    chk("glitch_sw", q, 16'h0000);

    switches = 8'h03;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (sw_irq) begin
        lat = i;
        break;
      end
    end
    @(negedge clk);
    chk("sw_latency", lat, 6);
    bus(1'b0, 1'b1, 16'hFF02, 16'h0);
    chk("sw_read", q, 16'h0003);
    switches = 8'h05;
    repeat (2) @(negedge clk);
    switches = 8'h03;
    repeat (10) @(negedge clk);
    bus(1'b0, 1'b1, 16'hFF02, 16'h0);
    chk("sw_after_glitch", q, 16'h0003);

    bus(1'b1, 1'b0, 16'hFF03, 16'h0001);
    chk("irq_clear", sw_irq, 1'b0);
    switches = 8'h0C;
    repeat (5) @(negedge clk);
    chk("pre_accept_irq", sw_irq, 1'b0);
    bus(1'b1, 1'b0, 16'hFF03, 16'h0001);
    chk("set_wins", sw_irq, 1'b1);
    bus(1'b1, 1'b0, 16'hFF03, 16'h0000);
    chk("write0_noop", sw_irq, 1'b1);

    bus(1'b0, 1'b1, 16'hFE02, 16'h0);
    chk("oow_valid", q_valid, 1'b0);
    bus(1'b1, 1'b1, 16'hFF00, 16'hBEEF);
    chk("rw_same_pre", q, 16'h0070);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        switches = ($urandom_range(0, 1) == 1) ? 8'($urandom) : (switches ^ 8'h01);
      a = ($urandom_range(0, 3) != 0) ? (16'hFF00 | 16'($urandom_range(0, 3))) : 16'($urandom);
      bus($urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, a, 16'($urandom));
    end

    switches = 8'hA5;
    repeat (10) @(negedge clk);
    switches = 8'h5A;
    repeat (3) @(negedge clk);
    bus(1'b0, 1'b1, 16'hFF03, 16'h0);
    chk("pre_reset_irq", sw_irq, 1'b1);
    #2;
    reset = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_reset_q_valid", q_valid, 1'b0);
    chk("mid_reset_q", q, 16'h0000);
    chk("mid_reset_irq", sw_irq, 1'b0);
    chk("mid_reset_seg", seg, {4{7'h40}});
    repeat (2) @(negedge clk);
    reset = 1'b1;
    bus(1'b0, 1'b1, 16'hFF02, 16'h0);
    chk("post_reset_sw", q, 16'h0000);

    repeat (20) @(negedge clk);
    chk("reads_pending", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_io_ctrl.md
# mem_io_ctrl

Parametrised memory-mapped I/O peripheral on the CPU's data-memory port B bus. It replaces hard-wired switch and seven-segment wiring with a small register window that the CPU can read and write. It provides N hex digits with an enable and leading-zero blanking, synchronised and debounced switch inputs, and a sticky switch-change flag with a level interrupt.

## Interface
- DATA_W, 16, bus data width
- ADDR_W, 16, bus address width
- NUM_DIGITS, 4, seven-segment digits driven; 4*NUM_DIGITS ≤ DATA_W
- NUM_SW, 8, switch inputs; NUM_SW ≤ DATA_W
- BASE_ADDR, 16'hFF00, window base; low 2 bits must be 0
- DEBOUNCE_CYC, 4, consecutive stable cycles required to accept a switch change; ≥ 1
- clk  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-low; all state is cleared while low
- address  in  ADDR_W  bus address
- data_in  in  DATA_W  write data
- wren  in  1  write strobe, single cycle
- rden  in  1  read strobe, single cycle
- q  out  DATA_W  read data
- q_valid  out  1  high for exactly one cycle while q is valid
- switches  in  NUM_SW  raw asynchronous switch inputs
- seg  out  7*NUM_DIGITS  active-low segments; digit k occupies seg[7k+6:7k], with bit 0 = segment a
- sw_irq  out  1  level interrupt, equal to STATUS[0]

## Operation
- A bus access hits the window when address[ADDR_W-1:2] == BASE_ADDR[ADDR_W-1:2]. Accesses outside the window are ignored, and q_valid stays 0.
- Register map, by offset address[1:0]:
  - 0 DISP (R/W): bits [4*NUM_DIGITS-1:0] hold the hex digits; digit k = DISP[4k+3:4k]. Upper bits read 0.
  - 1 CTRL (R/W): bit0 EN selects display on (1) or all segments off (0). Bit1 LZB enables leading-zero blanking. Other bits read 0.
  - 2 SW (RO): debounced switch vector, zero-extended. Writes are ignored.
  - 3 STATUS: bit0 CHG, sticky. Writing 1 to bit0 clears it; writing 0 has no effect.
- Reset values: DISP=0, CTRL=1, SW stable=0, CHG=0.
- Segment encoding uses standard active-low hex patterns: 0=7'b1000000, 1=7'b1111001, 7=7'b1111000, 8=7'b0000000, A=7'b0001000, F=7'b0001110. Blank=7'b1111111.
- Leading-zero blanking, active when LZB=1 and EN=1:
  - Scan from the top digit downward and blank digits while their value is 0.
  - Blanking stops at the first nonzero digit.
  - Digit 0 is never blanked.
- Switch path:
  - A two-flop synchroniser feeds a sampled vector `sync`.
  - The debounce counter clears whenever sync == stable or sync differs from its previous-cycle value.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYC-1 with sync still unchanged:
    - stable <= sync
    - CHG <= 1
    - the counter clears
- Debounce state machine: IDLE (sync == stable) → COUNT (sync ≠ stable, holding) → ACCEPT (single cycle, updates stable) → IDLE. A glitch during COUNT returns to COUNT with the counter cleared, or to IDLE if sync == stable again.

## Timing
- A write takes effect on the clk edge where wren is high. seg reflects the new DISP/CTRL on the following edge: one cycle of registered decode.
- Read: rden high at edge N registers q and q_valid at edge N. Both are visible in the cycle after N. q_valid drops at edge N+1 unless another read hits. When idle, q holds its last value.
- Simultaneous wren and rden to the same offset: the write occurs and q returns the pre-write value.
- Simultaneous CHG set (ACCEPT) and write-1-to-clear: set wins, so CHG=1.
- Switch latency from a clean input change to the SW register update: 2 synchroniser cycles + DEBOUNCE_CYC cycles. CHG and sw_irq rise on the same edge as the SW update.
- Asynchronous reset assertion mid-operation clears all state immediately. Outputs under reset:
  - q=0, q_valid=0, sw_irq=0
  - seg = digit "0" pattern on all digits (DISP=0, EN=1, LZB=0)
- No state changes occur while reset is low.

## Test plan
- Reset then idle: read CTRL at 16'hFF01. Expect q=16'h0001, q_valid pulses 1 cycle, and seg = 4× 7'b1000000.
- Write DISP=16'h1A70, then read it back at 16'hFF00. Expect seg digits 3..0 = 1, A, 7, 0 patterns one cycle after the write, and q=16'h1A70.
- Write CTRL=16'h0003 with DISP=16'h0070. Expect digits 3 and 2 blanked (7'h7F), digit 1 = "7", digit 0 = "0". Write CTRL=0 and expect all seg=1s.
- Switches 8'h00→8'h03 held steady with DEBOUNCE_CYC=4. Expect SW=16'h0003 and sw_irq=1 exactly 6 cycles after the change. A 2-cycle glitch to 8'h05 produces no SW change and no CHG.
- With CHG=1, write STATUS=16'h0001. Expect sw_irq→0 the next cycle. Repeat with the clear coincident with an ACCEPT and expect CHG to remain 1.
- Read 16'hFE02 (outside the window) and expect q_valid=0. Assert reset low mid-debounce and expect SW=0, CHG=0, and q_valid=0 immediately.
